axi4_lite_master: RTL and testbench
===================================

AXI4_LITE_MASTER -- requirements
Module: axi4_lite_master

Interface
REQ-001 TIMEOUT_CYCLES, 1024, non-IDLE cycles before abort; used only with AXI4_LITE_MASTER_TIMEOUT_EN.
REQ-002 clk  in  1  single clock; all logic on rising edge.
REQ-003 resetn  in  1  reset, asynchronous, active-low.
REQ-004 amci_addr  in  32  command byte address, sampled with amci_write/amci_read.
REQ-005 amci_wdata  in  32  write data, sampled with amci_write.
REQ-006 amci_write  in  1  one-cycle pulse requesting an AXI write.
REQ-007 amci_read  in  1  one-cycle pulse requesting an AXI read.
REQ-008 amci_rdata  out  32  data from the last completed read.
REQ-009 amci_resp  out  2  BRESP/RRESP of the last completed transaction.
REQ-010 amci_idle  out  1  1 = FSM in IDLE and no command pending.
REQ-011 M_AXI_AWADDR  out  32  write address.
REQ-012 M_AXI_AWVALID  out  1  write-address valid.
REQ-013 M_AXI_AWREADY  in  1  write-address ready.
REQ-014 M_AXI_AWPROT  out  3  constant 0.
REQ-015 M_AXI_WDATA  out  32  write data.
REQ-016 M_AXI_WSTRB  out  4  constant 4'hF.
REQ-017 M_AXI_WVALID  out  1  write-data valid.
REQ-018 M_AXI_WREADY  in  1  write-data ready.
REQ-019 M_AXI_BRESP  in  2  write response.
REQ-020 M_AXI_BVALID  in  1  write-response valid.
REQ-021 M_AXI_BREADY  out  1  write-response ready.
REQ-022 M_AXI_ARADDR  out  32  read address.
REQ-023 M_AXI_ARVALID  out  1  read-address valid.
REQ-024 M_AXI_ARPROT  out  3  constant 0.
REQ-025 M_AXI_ARREADY  in  1  read-address ready.
REQ-026 M_AXI_RDATA  in  32  read data.
REQ-027 M_AXI_RVALID  in  1  read-data valid.
REQ-028 M_AXI_RRESP  in  2  read response.
REQ-029 M_AXI_RREADY  out  1  read-data ready.

Function
REQ-030 Single FSM, states IDLE, W_ADDR, W_RESP, R_ADDR, R_DATA; one transaction outstanding at a time.
REQ-031 IDLE + amci_write: latch addr/wdata; next cycle AWVALID=WVALID=1, state W_ADDR; amci_write has priority over simultaneous amci_read, which is dropped.
REQ-032 W_ADDR: AWVALID clears the cycle after its AW handshake, WVALID the cycle after its W handshake, independently; when both done, BREADY=1, state W_RESP.
REQ-033 W_RESP: on BVALID&&BREADY capture BRESP into amci_resp, BREADY=0, state IDLE.
REQ-034 IDLE + amci_read: latch addr; next cycle ARVALID=1, state R_ADDR; after AR handshake ARVALID=0, RREADY=1, state R_DATA; on RVALID&&RREADY capture RDATA/RRESP, RREADY=0, IDLE.
REQ-035 AWADDR/WDATA/ARADDR come from latched registers, stable while corresponding VALID is high.
REQ-036 amci_idle = (state==IDLE) && !amci_write && !amci_read (combinational); commands arriving outside IDLE are ignored.
REQ-037 Zero-wait slave (READY=1, response the cycle after handshake): command cycle 0, VALID cycle 1, BREADY/RREADY cycle 2, amci_idle=1 and result valid cycle 3.
REQ-038 amci_rdata changes only on read completion; amci_resp holds until the next completion.

Reset
REQ-039 resetn=0 immediately: state IDLE, all VALID/READY outputs 0, amci_resp=0, amci_rdata=0, latched addr/data 0; any in-flight transaction abandoned.

Configuration
REQ-040 AXI4_LITE_MASTER_TIMEOUT_EN defined: counter clears in IDLE, increments each non-IDLE cycle; reaching TIMEOUT_CYCLES forces all VALID/READY to 0, amci_resp=2'b10, amci_rdata=32'hDEADDEAD (reads only), state IDLE.
REQ-041 Macro undefined: no counter logic; FSM waits indefinitely for slave handshakes.

Verification
REQ-042 Zero-wait write addr 0x04 data 0xCAFEF00D, BRESP=0 -> AW/WVALID cycle 1, BREADY cycle 2, amci_idle=1 cycle 3, amci_resp=0.
REQ-043 Read addr 0x08, slave RDATA=0x12345678 RRESP=0 -> amci_rdata=0x12345678, amci_resp=0, idle cycle 3.
REQ-044 AWREADY delayed 5 cycles, WREADY=1 -> WVALID low from cycle 2, AWVALID high cycles 1-6, AWADDR stable 0x04.
REQ-045 BRESP=3 -> amci_resp=3; amci_write+amci_read same cycle -> only AW/W issued, ARVALID never asserted.
REQ-046 Macro on, TIMEOUT_CYCLES=16, ARREADY held 0 -> ARVALID drops after 16 cycles, amci_resp=2, amci_rdata=0xDEADDEAD; macro off -> ARVALID still 1 at cycle 1000.
REQ-047 resetn low during W_RESP -> BREADY/all VALIDs 0 same cycle, amci_idle=1, amci_resp=0.

Source files
------------

// File: rtl/axi4_lite_master.sv
// Single-outstanding AXI4-Lite master driven by one-cycle command pulses.
// Optional macro AXI4_LITE_MASTER_TIMEOUT_EN adds a watchdog that aborts stalled transactions.
//
// state    | meaning
// ---------+-------------------------------------------------
// S_IDLE   | waiting for amci_write / amci_read pulse
// S_W_ADDR | AW and W channels presented, each retires on its own
// S_W_RESP | BREADY high, waiting for BVALID
// S_R_ADDR | ARVALID high, waiting for ARREADY
// S_R_DATA | RREADY high, waiting for RVALID
module axi4_lite_master #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] amci_addr,
  input  logic [31:0] amci_wdata,
  input  logic        amci_write,
  input  logic        amci_read,
  output logic [31:0] amci_rdata,
  output logic [1:0]  amci_resp,
  output logic        amci_idle,
  output logic [31:0] M_AXI_AWADDR,
  output logic        M_AXI_AWVALID,
  input  logic        M_AXI_AWREADY,
  output logic [2:0]  M_AXI_AWPROT,
  output logic [31:0] M_AXI_WDATA,
  output logic [3:0]  M_AXI_WSTRB,
  output logic        M_AXI_WVALID,
  input  logic        M_AXI_WREADY,
  input  logic [1:0]  M_AXI_BRESP,
  input  logic        M_AXI_BVALID,
  output logic        M_AXI_BREADY,
  output logic [31:0] M_AXI_ARADDR,
  output logic        M_AXI_ARVALID,
  output logic [2:0]  M_AXI_ARPROT,
  input  logic        M_AXI_ARREADY,
  input  logic [31:0] M_AXI_RDATA,
  input  logic        M_AXI_RVALID,
  input  logic [1:0]  M_AXI_RRESP,
  output logic        M_AXI_RREADY
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_W_ADDR = 3'd1,
    S_W_RESP = 3'd2,
    S_R_ADDR = 3'd3,
    S_R_DATA = 3'd4
  } state_t;

  state_t      r_state;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic [1:0]  r_resp;
  logic        r_awvalid;
  logic        r_wvalid;
  logic        r_bready;
  logic        r_arvalid;
  logic        r_rready;
  logic        w_abort;
  logic        w_aw_done;
  logic        w_w_done;

`ifdef AXI4_LITE_MASTER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] r_tcnt;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      r_tcnt <= '0;
    else if (r_state == S_IDLE)
      r_tcnt <= '0;
    else
      r_tcnt <= r_tcnt + 1'b1;
  end

  // Abort on the edge that ends the TIMEOUT_CYCLES-th busy cycle.
  assign w_abort = (r_state != S_IDLE) && (r_tcnt == TW'(TIMEOUT_CYCLES - 1));
`else
  // Watchdog absent; the parameter stays so both builds share one interface.
  assign w_abort = (TIMEOUT_CYCLES == 0) && 1'b0;
`endif

  assign w_aw_done = !r_awvalid || M_AXI_AWREADY;
  assign w_w_done  = !r_wvalid  || M_AXI_WREADY;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state   <= S_IDLE;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_rdata   <= '0;
      r_resp    <= '0;
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
      r_bready  <= 1'b0;
      r_arvalid <= 1'b0;
      r_rready  <= 1'b0;
    end else if (w_abort) begin
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
      r_bready  <= 1'b0;
      r_arvalid <= 1'b0;
      r_rready  <= 1'b0;
      r_resp    <= 2'b10;
      if (r_state == S_R_ADDR || r_state == S_R_DATA)
        r_rdata <= 32'hDEADDEAD;
      r_state   <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (amci_write) begin
            r_addr    <= amci_addr;
            r_wdata   <= amci_wdata;
            r_awvalid <= 1'b1;
            r_wvalid  <= 1'b1;
            r_state   <= S_W_ADDR;
          end else if (amci_read) begin
            r_addr    <= amci_addr;
            r_arvalid <= 1'b1;
            r_state   <= S_R_ADDR;
          end
        end
        S_W_ADDR: begin
          if (r_awvalid && M_AXI_AWREADY) r_awvalid <= 1'b0;
          if (r_wvalid && M_AXI_WREADY)   r_wvalid  <= 1'b0;
          if (w_aw_done && w_w_done) begin
            r_bready <= 1'b1;
            r_state  <= S_W_RESP;
          end
        end
        S_W_RESP: begin
          if (M_AXI_BVALID && r_bready) begin
            r_resp   <= M_AXI_BRESP;
            r_bready <= 1'b0;
            r_state  <= S_IDLE;
          end
        end
        S_R_ADDR: begin
          if (M_AXI_ARREADY) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= S_R_DATA;
          end
        end
        S_R_DATA: begin
          if (M_AXI_RVALID && r_rready) begin
            r_rdata  <= M_AXI_RDATA;
            r_resp   <= M_AXI_RRESP;
            r_rready <= 1'b0;
            r_state  <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign amci_idle     = (r_state == S_IDLE) && !amci_write && !amci_read;
  assign amci_rdata    = r_rdata;
  assign amci_resp     = r_resp;
  assign M_AXI_AWADDR  = r_addr;
  assign M_AXI_AWVALID = r_awvalid;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_WDATA   = r_wdata;
  assign M_AXI_WSTRB   = 4'hF;
  assign M_AXI_WVALID  = r_wvalid;
  assign M_AXI_BREADY  = r_bready;
  assign M_AXI_ARADDR  = r_addr;
  assign M_AXI_ARVALID = r_arvalid;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_RREADY  = r_rready;

endmodule

// File: tb/tb_axi4_lite_master.sv
// Bench for axi4_lite_master: table vectors, random transactions against a latency/result model,
// and hand sequences for stalls, command collisions, watchdog (AXI4_LITE_MASTER_TIMEOUT_EN) and reset.
module tb_axi4_lite_master;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [31:0] amci_addr = '0;
  logic [31:0] amci_wdata = '0;
  logic        amci_write = 1'b0;
  logic        amci_read = 1'b0;
  logic [31:0] amci_rdata;
  logic [1:0]  amci_resp;
  logic        amci_idle;
  logic [31:0] M_AXI_AWADDR;
  logic        M_AXI_AWVALID;
  logic        M_AXI_AWREADY;
  logic [2:0]  M_AXI_AWPROT;
  logic [31:0] M_AXI_WDATA;
  logic [3:0]  M_AXI_WSTRB;
  logic        M_AXI_WVALID;
  logic        M_AXI_WREADY;
  logic [1:0]  M_AXI_BRESP;
  logic        M_AXI_BVALID;
  logic        M_AXI_BREADY;
  logic [31:0] M_AXI_ARADDR;
  logic        M_AXI_ARVALID;
  logic [2:0]  M_AXI_ARPROT;
  logic        M_AXI_ARREADY;
  logic [31:0] M_AXI_RDATA;
  logic        M_AXI_RVALID;
  logic [1:0]  M_AXI_RRESP;
  logic        M_AXI_RREADY;

  axi4_lite_master #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .resetn(resetn),
    .amci_addr(amci_addr), .amci_wdata(amci_wdata),
    .amci_write(amci_write), .amci_read(amci_read),
    .amci_rdata(amci_rdata), .amci_resp(amci_resp), .amci_idle(amci_idle),
    .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
    .M_AXI_AWPROT(M_AXI_AWPROT), .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
    .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY), .M_AXI_BRESP(M_AXI_BRESP),
    .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY), .M_AXI_ARADDR(M_AXI_ARADDR),
    .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARPROT(M_AXI_ARPROT), .M_AXI_ARREADY(M_AXI_ARREADY),
    .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RRESP(M_AXI_RRESP),
    .M_AXI_RREADY(M_AXI_RREADY)
  );

  always #5 clk = ~clk;

  // Slave model: each READY rises once its VALID has waited *_dly cycles;
  // B/R responses come the cycle after the last address/data handshake.
  int          aw_dly = 0, w_dly = 0, ar_dly = 0;
  logic        b_hold = 1'b0;
  logic [1:0]  s_bresp = '0, s_rresp = '0;
  logic [31:0] s_rdata = '0;
  int          aw_cnt, w_cnt, ar_cnt;
  logic        aw_got, w_got, s_bvalid, s_rvalid;
  logic [31:0] log_awaddr, log_wdata, log_araddr;
  logic        hs_aw, hs_w, hs_ar;

  assign M_AXI_AWREADY = M_AXI_AWVALID && (aw_cnt >= aw_dly);
  assign M_AXI_WREADY  = M_AXI_WVALID  && (w_cnt  >= w_dly);
  assign M_AXI_ARREADY = M_AXI_ARVALID && (ar_cnt >= ar_dly);
  assign hs_aw = M_AXI_AWVALID && M_AXI_AWREADY;
  assign hs_w  = M_AXI_WVALID  && M_AXI_WREADY;
  assign hs_ar = M_AXI_ARVALID && M_AXI_ARREADY;
  assign M_AXI_BVALID = s_bvalid;
  assign M_AXI_BRESP  = s_bresp;
  assign M_AXI_RVALID = s_rvalid;
  assign M_AXI_RDATA  = s_rdata;
  assign M_AXI_RRESP  = s_rresp;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0;
      aw_got <= 1'b0; w_got <= 1'b0; s_bvalid <= 1'b0; s_rvalid <= 1'b0;
    end else begin
      aw_cnt <= (M_AXI_AWVALID && !M_AXI_AWREADY) ? aw_cnt + 1 : 0;
      w_cnt  <= (M_AXI_WVALID  && !M_AXI_WREADY)  ? w_cnt + 1  : 0;
      ar_cnt <= (M_AXI_ARVALID && !M_AXI_ARREADY) ? ar_cnt + 1 : 0;
      if (hs_aw) log_awaddr <= M_AXI_AWADDR;
      if (hs_w)  log_wdata  <= M_AXI_WDATA;
      if (hs_ar) log_araddr <= M_AXI_ARADDR;
      if (s_bvalid && M_AXI_BREADY)
        s_bvalid <= 1'b0;
      else if (!s_bvalid && !b_hold && (aw_got || hs_aw) && (w_got || hs_w)) begin
        s_bvalid <= 1'b1; aw_got <= 1'b0; w_got <= 1'b0;
      end else begin
        if (hs_aw) aw_got <= 1'b1;
        if (hs_w)  w_got  <= 1'b1;
      end
      if (s_rvalid && M_AXI_RREADY) s_rvalid <= 1'b0;
      else if (hs_ar)               s_rvalid <= 1'b1;
    end
  end

  int arv_count = 0;
  always @(negedge clk) if (M_AXI_ARVALID) arv_count++;

  int n_cmp = 0, n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Issues one command; lat = cycle index (command cycle = 0) at which amci_idle is first seen.
  task automatic run_txn(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                         output int lat);
    @(negedge clk);
    amci_addr = addr; amci_wdata = wdata; amci_write = wr; amci_read = !wr;
    @(negedge clk);
    amci_write = 1'b0; amci_read = 1'b0;
    lat = 1;
    while (!amci_idle && lat < 200) begin
      @(negedge clk);
      lat++;
    end
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] addr, wdata, rdata;
    logic [1:0]  resp;
    int          aw_d, w_d, ar_d;
    int          exp_lat;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int lat, k, base, exp_lat;
    bit wr;
    logic [31:0] addr, wdata, model_rdata;
    logic [1:0]  model_resp;

    vecs[0] = '{1'b1, 32'h04, 32'hCAFEF00D, 32'h0,        2'd0, 0, 0, 0, 3, 32'h0};
    vecs[1] = '{1'b0, 32'h08, 32'h0,        32'h12345678, 2'd0, 0, 0, 0, 3, 32'h12345678};
    vecs[2] = '{1'b1, 32'h10, 32'h11112222, 32'h0,        2'd3, 2, 0, 0, 5, 32'h12345678};
    vecs[3] = '{1'b0, 32'h0C, 32'h0,        32'hA5A5A5A5, 2'd2, 0, 0, 3, 6, 32'hA5A5A5A5};
    vecs[4] = '{1'b1, 32'h20, 32'h0BADBEEF, 32'h0,        2'd1, 0, 4, 0, 7, 32'hA5A5A5A5};
    vecs[5] = '{1'b0, 32'h30, 32'h0,        32'h0,        2'd1, 0, 0, 0, 3, 32'h0};

    #12;
    check("rst_awvalid", M_AXI_AWVALID, 0);
    check("rst_wvalid",  M_AXI_WVALID, 0);
    check("rst_bready",  M_AXI_BREADY, 0);
    check("rst_arvalid", M_AXI_ARVALID, 0);
    check("rst_rready",  M_AXI_RREADY, 0);
    check("rst_idle",    amci_idle, 1);
    check("rst_resp",    amci_resp, 0);
    check("rst_rdata",   amci_rdata, 0);
    check("rst_addr",    M_AXI_AWADDR, 0);
    check("wstrb",       M_AXI_WSTRB, 4'hF);
    check("prot",        {M_AXI_AWPROT, M_AXI_ARPROT}, 0);
    @(negedge clk); resetn = 1'b1;

    foreach (vecs[i]) begin
      aw_dly = vecs[i].aw_d; w_dly = vecs[i].w_d; ar_dly = vecs[i].ar_d;
      s_bresp = vecs[i].resp; s_rresp = vecs[i].resp; s_rdata = vecs[i].rdata;
      run_txn(vecs[i].wr, vecs[i].addr, vecs[i].wdata, lat);
      check($sformatf("vec%0d_lat", i), lat, vecs[i].exp_lat);
      check($sformatf("vec%0d_resp", i), amci_resp, vecs[i].resp);
      check($sformatf("vec%0d_rdata", i), amci_rdata, vecs[i].exp_rdata);
      if (vecs[i].wr) begin
        check($sformatf("vec%0d_awaddr", i), log_awaddr, vecs[i].addr);
        check($sformatf("vec%0d_wdata", i), log_wdata, vecs[i].wdata);
      end else
        check($sformatf("vec%0d_araddr", i), log_araddr, vecs[i].addr);
    end

    // Random transactions against a model of results and handshake-derived latency.
    model_rdata = amci_rdata;
    model_resp  = amci_resp;
    for (int t = 0; t < 40; t++) begin
      wr = 1'($urandom_range(0, 1));
      addr = $urandom & 32'hFFFF_FFFC;
      wdata = $urandom;
      aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3); ar_dly = $urandom_range(0, 3);
      s_bresp = 2'($urandom_range(0, 3)); s_rresp = 2'($urandom_range(0, 3)); s_rdata = $urandom;
      if (wr) begin
        exp_lat = 3 + ((aw_dly > w_dly) ? aw_dly : w_dly);
        model_resp = s_bresp;
      end else begin
        exp_lat = 3 + ar_dly;
        model_resp = s_rresp;
        model_rdata = s_rdata;
      end
      run_txn(wr, addr, wdata, lat);
      check($sformatf("rnd%0d_lat", t), lat, exp_lat);
      check($sformatf("rnd%0d_resp", t), amci_resp, model_resp);
      check($sformatf("rnd%0d_rdata", t), amci_rdata, model_rdata);
      if (wr) check($sformatf("rnd%0d_wdata", t), log_wdata, wdata);
      else    check($sformatf("rnd%0d_araddr", t), log_araddr, addr);
    end

    // AWREADY held off 5 cycles: AWVALID spans cycles 1-6 with a stable address, WVALID only cycle 1.
    aw_dly = 5; w_dly = 0; ar_dly = 0; s_bresp = 2'd0;
    @(negedge clk);
    amci_addr = 32'h04; amci_wdata = 32'h55AA55AA; amci_write = 1'b1;
    @(negedge clk);
    amci_write = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      check($sformatf("stall_c%0d_awvalid", c), M_AXI_AWVALID, (c <= 6) ? 1 : 0);
      check($sformatf("stall_c%0d_wvalid", c), M_AXI_WVALID, (c == 1) ? 1 : 0);
      if (c <= 6) check($sformatf("stall_c%0d_awaddr", c), M_AXI_AWADDR, 32'h04);
      if (c < 8) @(negedge clk);
    end
    check("stall_idle", amci_idle, 1);
    aw_dly = 0;

    // Simultaneous write+read: only the write runs.
    base = arv_count;
    s_bresp = 2'd3;
    @(negedge clk);
    amci_addr = 32'h40; amci_wdata = 32'h77778888; amci_write = 1'b1; amci_read = 1'b1;
    @(negedge clk);
    amci_write = 1'b0; amci_read = 1'b0;
    k = 1;
    while (!amci_idle && k < 200) begin @(negedge clk); k++; end
    check("both_lat", k, 3);
    check("both_no_ar", arv_count - base, 0);
    check("both_resp", amci_resp, 3);
    check("both_awaddr", log_awaddr, 32'h40);

    // Read pulse while busy is dropped.
    aw_dly = 3; s_bresp = 2'd1; base = arv_count;
    @(negedge clk);
    amci_addr = 32'h44; amci_write = 1'b1;
    @(negedge clk);
    amci_write = 1'b0;
    @(negedge clk);
    amci_read = 1'b1;
    @(negedge clk);
    amci_read = 1'b0;
    k = 0;
    while (!amci_idle && k < 200) begin @(negedge clk); k++; end
    @(negedge clk);
    check("busy_read_dropped", arv_count - base, 0);
    check("busy_resp", amci_resp, 1);
    aw_dly = 0;

    // ARREADY never comes.
    ar_dly = 100000;
    @(negedge clk);
    amci_addr = 32'h50; amci_read = 1'b1;
    @(negedge clk);
    amci_read = 1'b0;
`ifdef AXI4_LITE_MASTER_TIMEOUT_EN
    for (int c = 1; c < 16; c++) @(negedge clk);
    check("to_arvalid_c16", M_AXI_ARVALID, 1);
    @(negedge clk);
    check("to_arvalid_c17", M_AXI_ARVALID, 0);
    check("to_idle", amci_idle, 1);
    check("to_resp", amci_resp, 2);
    check("to_rdata", amci_rdata, 32'hDEADDEAD);
    ar_dly = 0;
`else
    for (int c = 1; c < 1000; c++) @(negedge clk);
    check("noto_arvalid_c1000", M_AXI_ARVALID, 1);
    check("noto_busy", amci_idle, 0);
    resetn = 1'b0;
    ar_dly = 0;
    @(negedge clk);
    resetn = 1'b1;
`endif

    // Reset while waiting in W_RESP.
    b_hold = 1'b1; s_bresp = 2'd0;
    @(negedge clk);
    amci_addr = 32'h60; amci_wdata = 32'h13572468; amci_write = 1'b1;
    @(negedge clk);
    amci_write = 1'b0;
    @(negedge clk);
    check("wresp_bready", M_AXI_BREADY, 1);
    #2 resetn = 1'b0;
    #1;
    check("rstmid_bready", M_AXI_BREADY, 0);
    check("rstmid_valids", {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_ARVALID, M_AXI_RREADY}, 0);
    check("rstmid_idle", amci_idle, 1);
    check("rstmid_resp", amci_resp, 0);
    check("rstmid_rdata", amci_rdata, 0);
    @(negedge clk);
    resetn = 1'b1; b_hold = 1'b0;

    s_rdata = 32'h0F0F0F0F; s_rresp = 2'd0;
    run_txn(1'b0, 32'h70, 32'h0, lat);
    check("post_rst_lat", lat, 3);
    check("post_rst_rdata", amci_rdata, 32'h0F0F0F0F);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
